codes_rr_arb4: RTL
==================

Name: codes_rr_arb4

Overview:
- 4-requester round-robin arbiter for a shared resource. Selects one requester, holds the grant while the request stays high, and caps the hold time.
- Drives a one-hot grant plus its 4-to-2 encoded index, so downstream muxes steer directly.
- Sits between requesting units and a single shared datapath port.

Parameters:
- MAX_HOLD, default 8: max consecutive grant cycles for one holder while another requester waits. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  4  request lines; bit i = requester i.
- grant  output  4  one-hot grant, or 0000 when idle.
- grant_idx  output  2  binary index of the set grant bit; 00 when idle.
- grant_val  output  1  1 when any grant is active (OR of grant).
- lock  input  1  present only when CODES_ARB_LOCK_EN is defined (see Optional Feature).

Behaviour:
- All outputs are registered.
- Internal state:
  - FSM with states IDLE and GRANT.
  - Holder index h (2b).
  - Priority pointer ptr (2b).
  - Hold counter cnt (8b).
- Reset (reset=0, asynchronous):
  - state=IDLE, ptr=0, h=0, cnt=0.
  - grant=0000, grant_idx=00, grant_val=0.
  - Takes effect without a clock edge. Reset asserted mid-grant drops the grant immediately.
- Winner selection: first requester with req=1 searching circularly ptr, ptr+1, ... ptr+3 (mod 4, so 3 wraps to 0).
- IDLE:
  - req==0000: stay IDLE.
  - Otherwise at the edge: go to GRANT, h=winner, cnt=0, grant=onehot(h).
  - Latency is 1 cycle from sampled req to visible grant.
- GRANT, release condition = (req[h]==0) OR (forced).
  - forced = MAX_HOLD!=0 AND cnt==MAX_HOLD-1 AND (req with bit h masked) != 0.
- On release:
  - ptr=h+1 mod 4.
  - Winner is computed from req with bit h masked, searching from h+1.
  - If there is a winner: grant moves to it in the same edge (no idle bubble), cnt=0.
  - If there is none: state=IDLE, outputs cleared.
- No release:
  - Hold grant.
  - cnt increments, saturating at 255.
  - If MAX_HOLD!=0 and no other requester is pending, cnt saturates at MAX_HOLD-1. The holder keeps the grant indefinitely until a competitor appears, then is preempted on the next edge.
- A holder that drops req and re-raises it in the same cycle as others is treated as released. It rejoins the rotation at lowest priority.
- Simultaneous release and new requests are resolved in one edge as above.
- grant_idx always equals the binary encoding of grant. grant is never multi-hot.

Optional Feature:
- Macro: CODES_ARB_LOCK_EN.
- Defined:
  - Input port lock is present.
  - While lock=1 and state=GRANT, forced release is suppressed and cnt holds its value.
  - Release occurs only on req[h]==0.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - Forced release always applies per MAX_HOLD.

Test Plan:
1. Reset low, then high; req=0001 → next cycle grant=0001, grant_idx=00, grant_val=1. Then req=0000 → next cycle grant=0000, grant_val=0.
2. MAX_HOLD=8, req=1111 held → grant_idx sequence 0,1,2,3,0, each lasting exactly 8 cycles, never 0000 between.
3. Holder 0 with req=0001 for 20 cycles → no preemption. At cycle 20, req=0011 → grant moves to 0010 on the next edge (cnt already at 7).
4. Grant held by 2, req changes 0100→0001 → next cycle grant=0001 (wrap search 3→0), ptr=3.
5. Grant=0100 active, reset pulsed low mid-cycle → grant=0000 before the next edge. After reset release, req=1001 → grant=0001 (ptr back to 0).
6. CODES_ARB_LOCK_EN, lock=1, req=1111, holder 1 → holds 30 cycles. lock=0 → grant=0100 on the next edge.

Source files
------------

// File: rtl/codes_rr_arb4.sv
// 4-requester round-robin arbiter with a bounded hold time and registered one-hot/encoded grant.
// Optional build macro CODES_ARB_LOCK_EN adds a lock input that suppresses forced release.
module codes_rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
`ifdef CODES_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_val
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_h;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;
    logic [3:0] r_grant;
    logic [1:0] r_grant_idx;
    logic       r_grant_val;

    state_t     w_state_nxt;
    logic [1:0] w_h_nxt;
    logic [1:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] w_others;
    logic [2:0] w_pick_idle;
    logic [2:0] w_pick_rel;
    logic       w_lock;
    logic       w_forced;
    logic       w_release;

    // Returns {found, index} of the first set bit scanning circularly from start.
    function automatic logic [2:0] f_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            k = start + 2'(i);
            if (!res[2] && r[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

`ifdef CODES_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_others    = req & ~(4'b0001 << r_h);
    assign w_pick_idle = f_pick(req, r_ptr);
    assign w_pick_rel  = f_pick(w_others, r_h + 2'd1);
    assign w_forced    = HOLD_EN && (r_cnt == HOLD_LAST) && (w_others != 4'b0000) && !w_lock;
    assign w_release   = !req[r_h] || w_forced;

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    w_state_nxt = ST_GRANT;
                    w_h_nxt     = w_pick_idle[1:0];
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // Hand off in the same edge when someone else is waiting.
                    w_ptr_nxt = r_h + 2'd1;
                    w_cnt_nxt = 8'd0;
                    if (w_pick_rel[2]) begin
                        w_h_nxt = w_pick_rel[1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_lock) begin
                    w_cnt_nxt = r_cnt;
                end else if (HOLD_EN && (w_others == 4'b0000)) begin
                    // Uncontested holder parks at the preemption threshold.
                    w_cnt_nxt = (r_cnt >= HOLD_LAST) ? HOLD_LAST : r_cnt + 8'd1;
                end else begin
                    w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_h         <= 2'd0;
            r_ptr       <= 2'd0;
            r_cnt       <= 8'd0;
            r_grant     <= 4'b0000;
            r_grant_idx <= 2'd0;
            r_grant_val <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == ST_GRANT) begin
                r_grant     <= 4'b0001 << w_h_nxt;
                r_grant_idx <= w_h_nxt;
                r_grant_val <= 1'b1;
            end else begin
                r_grant     <= 4'b0000;
                r_grant_idx <= 2'd0;
                r_grant_val <= 1'b0;
            end
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign grant_val = r_grant_val;

endmodule
